// File: rtl/universal_shift_reg.sv
// ----------------------------------------------------------------------------
// universal_shift_reg
//
// WIDTH-bit edge-triggered universal shift register. On each enabled rising
// edge of Clk it holds, shifts right, shifts left or parallel-loads.
// Shifts either fill from a serial input or rotate the outgoing bit back in.
// It also counts shifts since the last load, saturating at WIDTH. Done flags
// that a full word has been shifted out.
//
// Ports
//   Clk     in   1      rising-edge clock
//   Resetn  in   1      asynchronous active-low reset
//   En      in   1      clock enable; 0 freezes every output
//   Mode    in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   Rotate  in   1      1 = shifts wrap the outgoing bit, serial ins ignored
//   D       in   WIDTH  parallel load data
//   SerInR  in   1      bit entering Q[WIDTH-1] on right shift (Rotate=0)
//   SerInL  in   1      bit entering Q[0] on left shift (Rotate=0)
//   Q       out  WIDTH  register contents
//   SerOut  out  1      last bit shifted out
//   Count   out  CW     shifts since last load, saturating at WIDTH
//   Done    out  1      Count == WIDTH
// ----------------------------------------------------------------------------
module universal_shift_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CW          = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic             Rotate,
    input  logic [WIDTH-1:0] D,
    input  logic             SerInR,
    input  logic             SerInL,
    output logic [WIDTH-1:0] Q,
    output logic             SerOut,
    output logic [CW-1:0]    Count,
    output logic             Done
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_RIGHT = 2'b01;
    localparam logic [1:0]    MODE_LEFT  = 2'b10;
    localparam logic [1:0]    MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic             ser_out_nxt;
    logic [CW-1:0]    count_nxt;
    logic             done_nxt;
    logic             shift;
    logic             in_right;
    logic             in_left;

    // Bit entering the register for each direction.
    assign in_right = Rotate ? Q[0]       : SerInR;
    assign in_left  = Rotate ? Q[WIDTH-1] : SerInL;

    always_comb begin
        q_nxt       = Q;
        ser_out_nxt = SerOut;
        count_nxt   = Count;
        done_nxt    = Done;
        shift       = 1'b0;

        if (En) begin
            case (Mode)
                MODE_RIGHT: begin
                    q_nxt       = {in_right, Q[WIDTH-1:1]};
                    ser_out_nxt = Q[0];
                    shift       = 1'b1;
                end
                MODE_LEFT: begin
                    q_nxt       = {Q[WIDTH-2:0], in_left};
                    ser_out_nxt = Q[WIDTH-1];
                    shift       = 1'b1;
                end
                MODE_LOAD: begin
                    q_nxt     = D;
                    count_nxt = '0;
                    done_nxt  = 1'b0;
                end
                default: begin
                    // MODE_HOLD: nothing changes
                end
            endcase
        end

        // Count never exceeds COUNT_FULL, so != acts as "< WIDTH".
        if (shift) begin
            if (Count != COUNT_FULL) begin
                count_nxt = Count + CW'(1);
            end
            done_nxt = (count_nxt == COUNT_FULL);
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            Q      <= RESET_VALUE;
            SerOut <= 1'b0;
            Count  <= '0;
            Done   <= 1'b0;
        end else begin
            Q      <= q_nxt;
            SerOut <= ser_out_nxt;
            Count  <= count_nxt;
            Done   <= done_nxt;
        end
    end

endmodule
